kf_pilot_feeder: RTL and testbench

- Drives the measurement side of kf_mimo2x2_core.
- Collects one 2x2 complex pilot matrix (8 signed words) from a valid/ready stream into a collection buffer.
- Transfers the matrix to stable hold registers, pulses `en` once, then waits for `valid_all` before firing the next frame.
- Also sequences `load_init` after reset and on request, and flags framing errors and core timeouts.

---
 rtl/kf_pkg.sv | 28 ++
 rtl/kf_pilot_collector.sv | 72 +++++++
 rtl/kf_pilot_feeder.sv | 170 +++++++++++++++++
 tb/tb_kf_pilot_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared definitions for the kf_pilot_feeder block.
// Holds the default word width, the frame size, the word-index map of the
// 2x2 complex pilot matrix and the feeder state encoding.
package kf_pkg;

  localparam int WX_DEF = 16;  // pilot word width, Q1.15 signed
  localparam int NWORDS = 8;   // words per pilot frame
  localparam int IW     = 3;   // width of the word index

  // Stream order of the words inside one frame
  localparam int IDX_Z11_RE = 0;
  localparam int IDX_Z11_IM = 1;
  localparam int IDX_Z12_RE = 2;
  localparam int IDX_Z12_IM = 3;
  localparam int IDX_Z21_RE = 4;
  localparam int IDX_Z21_IM = 5;
  localparam int IDX_Z22_RE = 6;
  localparam int IDX_Z22_IM = 7;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_LOAD = 3'd1,
    S_IDLE = 3'd2,
    S_FIRE = 3'd3,
    S_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/kf_pilot_collector.sv
// Pilot word collector: accepts words from a valid/ready stream into an
// 8-word buffer, checks framing with s_last and marks the buffer full once a
// well-formed frame has arrived.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_s_valid/o_s_ready  stream handshake
//   i_s_data, i_s_last   stream word and end-of-frame marker
//   i_take               consumer has copied the buffer; frees it
//   o_buf_full           a complete frame is waiting in the buffer
//   o_buf_flat           buffer contents, word i at [i*WX +: WX]
//   o_frame_err_pulse    one-cycle flag: framing error on the accepted word
module kf_pilot_collector
  import kf_pkg::*;
#(
  parameter int WX = WX_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [WX-1:0]        i_s_data,
  input  logic                 i_s_last,
  input  logic                 i_take,
  output logic                 o_buf_full,
  output logic [NWORDS*WX-1:0] o_buf_flat,
  output logic                 o_frame_err_pulse
);

  logic [IW-1:0] r_idx;
  logic          r_buf_full;
  logic          w_accept;
  logic          w_last_idx;
  logic          w_good_end;

  assign o_s_ready  = !r_buf_full;
  assign o_buf_full = r_buf_full;
  assign w_accept   = i_s_valid && !r_buf_full;
  assign w_last_idx = (r_idx == IW'(NWORDS - 1));
  assign w_good_end = w_accept && w_last_idx && i_s_last;

  // Framing is wrong when s_last disagrees with the word position
  assign o_frame_err_pulse = w_accept && (w_last_idx != i_s_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_accept) begin
        // Either end of frame (good or bad) restarts the index
        if (w_last_idx || i_s_last) r_idx <= '0;
        else                        r_idx <= r_idx + 1'b1;
      end
      // Accept and take never coincide: accept needs an empty buffer
      if (w_good_end)  r_buf_full <= 1'b1;
      else if (i_take) r_buf_full <= 1'b0;
    end
  end

  // One register per word; a discarded frame is simply overwritten later
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [WX-1:0] r_word;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            r_word <= '0;
        else if (w_accept && r_idx == IW'(gi))   r_word <= i_s_data;
      end
      assign o_buf_flat[gi*WX +: WX] = r_word;
    end
  endgenerate

endmodule

// File: rtl/kf_pilot_feeder.sv
// Measurement-side feeder for kf_mimo2x2_core.
// Collects one 2x2 complex pilot matrix per frame, copies it to hold
// registers, pulses en and waits for valid_all (or a timeout) before the
// next frame. Sequences load_init after reset and on request.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_s_valid, o_s_ready,
//   i_s_data, i_s_last          pilot word stream
//   i_reinit                    request a new load_init pulse
//   i_err_clr                   clear sticky error flags
//   i_valid_all                 core finished the frame
//   o_load_init, o_en           control pulses to the core
//   o_z11_re .. o_z22_im        hold registers to the core
//   o_busy                      frame in flight (S_FIRE/S_WAIT)
//   o_frames_done               completed frames, wraps
//   o_timeout_err, o_frame_err  sticky error flags
module kf_pilot_feeder
  import kf_pkg::*;
#(
  parameter int WX      = WX_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [WX-1:0] i_s_data,
  input  logic          i_s_last,
  input  logic          i_reinit,
  input  logic          i_err_clr,
  output logic          o_load_init,
  output logic          o_en,
  output logic [WX-1:0] o_z11_re,
  output logic [WX-1:0] o_z11_im,
  output logic [WX-1:0] o_z12_re,
  output logic [WX-1:0] o_z12_im,
  output logic [WX-1:0] o_z21_re,
  output logic [WX-1:0] o_z21_im,
  output logic [WX-1:0] o_z22_re,
  output logic [WX-1:0] o_z22_im,
  input  logic          i_valid_all,
  output logic          o_busy,
  output logic [15:0]   o_frames_done,
  output logic          o_timeout_err,
  output logic          o_frame_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                      r_state, w_state_next;
  logic                        r_load_init, w_load_init_next;
  logic                        r_en, w_en_next;
  logic [CW-1:0]               r_wait_cnt, w_wait_cnt_next;
  logic [15:0]                 r_frames_done, w_frames_done_next;
  logic                        r_reinit_pend, w_reinit_pend_next;
  logic                        r_timeout_err, r_frame_err;
  logic                        w_timeout_set;
  logic                        w_take;
  logic                        w_buf_full;
  logic                        w_frame_err_pulse;
  logic [NWORDS*WX-1:0]        w_buf_flat;
  logic [NWORDS-1:0][WX-1:0]   r_z;

  kf_pilot_collector #(.WX(WX)) u_collector (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_s_valid         (i_s_valid),
    .o_s_ready         (o_s_ready),
    .i_s_data          (i_s_data),
    .i_s_last          (i_s_last),
    .i_take            (w_take),
    .o_buf_full        (w_buf_full),
    .o_buf_flat        (w_buf_flat),
    .o_frame_err_pulse (w_frame_err_pulse)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_INIT;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    w_load_init_next   = r_load_init;
    w_en_next          = r_en;
    w_wait_cnt_next    = r_wait_cnt;
    w_frames_done_next = r_frames_done;
    w_take             = 1'b0;
    w_timeout_set      = 1'b0;
    // A request arriving while not idle is remembered for the next idle
    w_reinit_pend_next = r_reinit_pend || (i_reinit && r_state != S_IDLE);
    case (r_state)
      S_INIT: begin
        w_load_init_next = 1'b1;
        w_state_next     = S_LOAD;
      end
      S_LOAD: begin
        w_load_init_next = 1'b0;
        w_state_next     = S_IDLE;
      end
      S_IDLE: begin
        if (i_reinit || r_reinit_pend) begin
          w_reinit_pend_next = 1'b0;
          w_state_next       = S_INIT;
        end else if (w_buf_full) begin
          w_take          = 1'b1;
          w_en_next       = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = S_FIRE;
        end
      end
      S_FIRE: begin
        w_en_next    = 1'b0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_wait_cnt_next = r_wait_cnt + 1'b1;
        if (i_valid_all) begin
          w_frames_done_next = r_frames_done + 16'd1;
          w_state_next       = S_IDLE;
        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_init   <= 1'b0;
      r_en          <= 1'b0;
      r_wait_cnt    <= '0;
      r_frames_done <= '0;
      r_reinit_pend <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_err   <= 1'b0;
      r_z           <= '0;
    end else begin
      r_load_init   <= w_load_init_next;
      r_en          <= w_en_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_frames_done <= w_frames_done_next;
      r_reinit_pend <= w_reinit_pend_next;
      // Set beats clear when both happen on the same edge
      r_timeout_err <= w_timeout_set || (r_timeout_err && !i_err_clr);
      r_frame_err   <= w_frame_err_pulse || (r_frame_err && !i_err_clr);
      // Holds change only when a frame fires, so they stay stable for the core
      if (w_take) r_z <= w_buf_flat;
    end
  end

  assign o_load_init   = r_load_init;
  assign o_en          = r_en;
  assign o_busy        = (r_state == S_FIRE) || (r_state == S_WAIT);
  assign o_frames_done = r_frames_done;
  assign o_timeout_err = r_timeout_err;
  assign o_frame_err   = r_frame_err;

  assign o_z11_re = r_z[IDX_Z11_RE];
  assign o_z11_im = r_z[IDX_Z11_IM];
  assign o_z12_re = r_z[IDX_Z12_RE];
  assign o_z12_im = r_z[IDX_Z12_IM];
  assign o_z21_re = r_z[IDX_Z21_RE];
  assign o_z21_im = r_z[IDX_Z21_IM];
  assign o_z22_re = r_z[IDX_Z22_RE];
  assign o_z22_im = r_z[IDX_Z22_IM];

endmodule

// File: tb/tb_kf_pilot_feeder.sv
module tb_kf_pilot_feeder;

  localparam int WX      = 16;
  localparam int TIMEOUT = 64;
  localparam int CORE_LAT = 12;

  typedef logic [7:0][WX-1:0] frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WX-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          reinit = 1'b0;
  logic          err_clr = 1'b0;
  logic          load_init;
  logic          en;
  logic [WX-1:0] zw [8];
  logic          valid_all = 1'b0;
  logic          busy;
  logic [15:0]   frames_done;
  logic          timeout_err;
  logic          frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int vcnt    = 0;
  bit core_respond = 1'b1;
  bit prev_en = 1'b0;
  frame_t sb[$];
  frame_t mon_f;

  always #5 clk = ~clk;

  kf_pilot_feeder #(.WX(WX), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_last(s_last),
    .i_reinit(reinit), .i_err_clr(err_clr),
    .o_load_init(load_init), .o_en(en),
    .o_z11_re(zw[0]), .o_z11_im(zw[1]), .o_z12_re(zw[2]), .o_z12_im(zw[3]),
    .o_z21_re(zw[4]), .o_z21_im(zw[5]), .o_z22_re(zw[6]), .o_z22_im(zw[7]),
    .i_valid_all(valid_all), .o_busy(busy), .o_frames_done(frames_done),
    .o_timeout_err(timeout_err), .o_frame_err(frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model and scoreboard consumer: compares the holds on every en and
  // answers with a one-cycle valid_all CORE_LAT edges after en.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      vcnt = 0;
      valid_all = 1'b0;
      prev_en = 1'b0;
    end else begin
      valid_all = 1'b0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) valid_all = 1'b1;
      end
      if (prev_en) check_eq("en_width", en, 0);
      if (en) begin
        en_cnt++;
        check_eq("en_has_frame", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_f = sb.pop_front();
          for (int i = 0; i < 8; i++)
            check_eq($sformatf("hold%0d", i), zw[i], mon_f[i]);
          $display("[TB] frame fired: z11=%0d,%0d z22=%0d,%0d", $signed(zw[0]),
                   $signed(zw[1]), $signed(zw[6]), $signed(zw[7]));
        end
        if (core_respond) vcnt = CORE_LAT;
      end
      prev_en = en;
    end
  end

  task automatic send(input frame_t f, input int n, input bit last_ok,
                      input bit clr_on_last, output int stalls);
    int budget;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = (i == n - 1) && last_ok;
      err_clr = (i == n - 1) && clr_on_last;
      budget  = 0;
      while (!s_ready && budget < 200) begin
        tick();
        stalls++;
        budget++;
      end
      if (!s_ready) check_eq("s_ready_wait", s_ready, 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    err_clr = 1'b0;
    if (n == 8 && last_ok) sb.push_back(f);
  endtask

  task automatic wait_frames(input int exp);
    int budget = 0;
    while (frames_done != 16'(exp) && budget < 100) begin
      tick();
      budget++;
    end
    check_eq("frames_done", frames_done, exp);
  endtask

  task automatic wait_en();
    int budget = 0;
    while (!en && budget < 100) begin
      tick();
      budget++;
    end
    check_eq("wait_en", en, 1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) check_eq($sformatf("%s_z%0d", tag, i), zw[i], 0);
    check_eq({tag, "_en"}, en, 0);
    check_eq({tag, "_load_init"}, load_init, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_frames"}, frames_done, 0);
    check_eq({tag, "_terr"}, timeout_err, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
  endtask

  frame_t f1, f2, f3, f4;
  int stalls, en_before, exp_frames;

  initial begin
    f1 = {16'(-4915), 16'(19661), 16'(3932), 16'(-9830), 16'(655), 16'(1638), 16'(-3277), 16'(26214)};
    for (int i = 0; i < 8; i++) begin
      f2[i] = 16'($urandom);
      f3[i] = 16'($urandom);
      f4[i] = 16'(1000 * i + 7);
    end
    exp_frames = 0;

    // Reset state and load_init sequencing
    repeat (3) tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();
    check_eq("li_edge1", load_init, 1);
    check_eq("en_edge1", en, 0);
    tick();
    check_eq("li_edge2", load_init, 0);
    check_eq("en_edge2", en, 0);

    // Frame 1: en exactly one edge after word 8, then frame 2 back-to-back
    send(f1, 8, 1, 0, stalls);
    check_eq("t1_busy_pre", busy, 0);
    tick();
    check_eq("t1_en_k1", en, 1);
    check_eq("t1_busy", busy, 1);
    tick();
    check_eq("t1_en_k2", en, 0);
    send(f2, 8, 1, 0, stalls);
    check_eq("t2_no_stall", stalls, 0);
    check_eq("t2_ready_low", s_ready, 0);
    exp_frames = 1;
    wait_frames(exp_frames);
    check_eq("t2_en_in_idle", en, 0);
    tick();
    check_eq("t2_en_after_idle", en, 1);
    check_eq("t2_ready_back", s_ready, 1);
    exp_frames = 2;
    wait_frames(exp_frames);

    // Early s_last: discarded, error flagged, next clean frame fires
    en_before = en_cnt;
    send(f3, 5, 1, 0, stalls);
    check_eq("t3_ferr_set", frame_err, 1);
    repeat (5) tick();
    check_eq("t3_no_en", en_cnt, en_before);
    send(f3, 8, 1, 0, stalls);
    exp_frames = 3;
    wait_frames(exp_frames);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("t3_ferr_clr", frame_err, 0);
    // Missing s_last on word 8 while err_clr is asserted: set wins
    send(f4, 8, 0, 1, stalls);
    check_eq("t3_set_wins", frame_err, 1);
    check_eq("t3_ready", s_ready, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("t3_ferr_clr2", frame_err, 0);

    // Timeout: core silent
    core_respond = 1'b0;
    send(f4, 8, 1, 0, stalls);
    wait_en();
    tick();
    check_eq("t4_en_fall", en, 0);
    repeat (TIMEOUT - 1) tick();
    check_eq("t4_terr_early", timeout_err, 0);
    check_eq("t4_busy", busy, 1);
    tick();
    check_eq("t4_terr_set", timeout_err, 1);
    check_eq("t4_frames", frames_done, exp_frames);
    core_respond = 1'b1;
    send(f2, 8, 1, 0, stalls);
    exp_frames = 4;
    wait_frames(exp_frames);

    // reinit during S_WAIT: load_init sequence precedes the buffered frame
    send(f1, 8, 1, 0, stalls);
    wait_en();
    tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    send(f3, 8, 1, 0, stalls);
    exp_frames = 5;
    wait_frames(exp_frames);
    tick();
    check_eq("t5_li_a", load_init, 0);
    check_eq("t5_en_a", en, 0);
    tick();
    check_eq("t5_li_b", load_init, 1);
    check_eq("t5_en_b", en, 0);
    tick();
    check_eq("t5_li_c", load_init, 0);
    check_eq("t5_en_c", en, 0);
    tick();
    check_eq("t5_en_d", en, 1);
    exp_frames = 6;
    wait_frames(exp_frames);

    // Reset mid-frame: outputs clear at once, partial frame discarded
    send(f4, 4, 0, 0, stalls);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    send(f2, 8, 1, 0, stalls);
    exp_frames = 1;
    wait_frames(exp_frames);
    check_eq("t6_ferr", frame_err, 0);
    check_eq("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
